// File: rtl/vec_mul_pkg.sv
// Shared constants and FSM encoding for the vector-multiplier result path.
package vec_mul_pkg;

  localparam int MATRIX_SIZE    = 64;
  localparam int PARTIAL_SUM_BW = 24;
  localparam int DATA_BW        = 8;
  localparam int ADDRESSSIZE    = 10;
  localparam int SHIFT_BW       = 5;

  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_t;

endpackage

// File: rtl/result_writeback_requant_lane.sv
// One lane of requantization: rounding arithmetic shift, then clip to 8 bits.
// RESULT_WB_RELU_EN selects ReLU (negatives to 0) instead of signed saturation.
module requant_lane
  import vec_mul_pkg::*;
(
  input  logic signed [PARTIAL_SUM_BW-1:0] x,
  input  logic        [SHIFT_BW-1:0]       shift,
  output logic        [DATA_BW-1:0]        q,
  output logic                             sat
);

  localparam int EXT_BW = PARTIAL_SUM_BW + 1;
  localparam logic signed [EXT_BW-1:0] HI    = EXT_BW'(SAT_MAX);
  localparam logic signed [EXT_BW-1:0] LO    = EXT_BW'(SAT_MIN);
  localparam logic        [DATA_BW-1:0] Q_MAX = DATA_BW'(SAT_MAX);
  localparam logic        [DATA_BW-1:0] Q_MIN = DATA_BW'(SAT_MIN);

  logic signed [EXT_BW-1:0] x_ext;
  logic        [EXT_BW-1:0] rnd;
  logic signed [EXT_BW-1:0] sum;
  logic signed [EXT_BW-1:0] r;

  always_comb begin
    x_ext = {x[PARTIAL_SUM_BW-1], x};
    // half-LSB of the shifted result; collapses to zero when shift is 0
    rnd   = (EXT_BW'(1) << shift) >> 1;
    sum   = x_ext + $signed(rnd);
    r     = sum >>> shift;
    q     = r[DATA_BW-1:0];
    sat   = 1'b0;
`ifdef RESULT_WB_RELU_EN
    if (r[EXT_BW-1]) begin
      q = '0;
    end else if (r > HI) begin
      q   = Q_MAX;
      sat = 1'b1;
    end
`else
    if (r > HI) begin
      q   = Q_MAX;
      sat = 1'b1;
    end else if (r < LO) begin
      q   = Q_MIN;
      sat = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/result_writeback.sv
// Result writeback: captures 64-lane partial sums, requantizes to 8 bits and
// writes one row per vector to the result buffer at incrementing addresses.
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_RUN   | accepting vectors until num_rows have been taken
// ST_DRAIN | no more accepts; waiting for the pipeline to empty
// ST_DONE  | one-cycle done pulse
module result_writeback
  import vec_mul_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 start,
  input  logic [ADDRESSSIZE-1:0]               base_addr,
  input  logic [ADDRESSSIZE-1:0]               num_rows,
  input  logic [SHIFT_BW-1:0]                  shift,
  input  logic                                 in_valid,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] in_data,
  output logic                                 in_ready,
  output logic                                 wr_en,
  output logic [ADDRESSSIZE-1:0]               wr_addr,
  output logic [DATA_BW*MATRIX_SIZE-1:0]       wr_data,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 sat_flag
);

  localparam logic [ADDRESSSIZE-1:0] ADDR_ONE = ADDRESSSIZE'(1);

  wb_state_t state, state_nxt;

  logic [ADDRESSSIZE-1:0] cfg_base;
  logic [ADDRESSSIZE-1:0] cfg_rows;
  logic [SHIFT_BW-1:0]    cfg_shift;
  logic [ADDRESSSIZE-1:0] acc_cnt;
  logic [ADDRESSSIZE-1:0] wr_idx;

  logic                                  s1_valid;
  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] s1_data;
  logic [DATA_BW*MATRIX_SIZE-1:0]        rq_data;
  logic [MATRIX_SIZE-1:0]                lane_sat;

  logic accept;
  logic last_accept;
  logic job_start;

  assign in_ready    = (state == ST_RUN) && (acc_cnt < cfg_rows);
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && ((acc_cnt + ADDR_ONE) == cfg_rows);
  assign job_start   = (state == ST_IDLE) && start;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    case (state)
      ST_IDLE:  if (start) state_nxt = (num_rows == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (last_accept) state_nxt = ST_DRAIN;
      // the stage-2 write is in flight once S1 empties, so done lands right after it
      ST_DRAIN: if (!s1_valid) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cfg_base  <= '0;
      cfg_rows  <= '0;
      cfg_shift <= '0;
      acc_cnt   <= '0;
      wr_idx    <= '0;
      sat_flag  <= 1'b0;
    end else if (job_start) begin
      cfg_base  <= base_addr;
      cfg_rows  <= num_rows;
      cfg_shift <= shift;
      acc_cnt   <= '0;
      wr_idx    <= '0;
      sat_flag  <= 1'b0;
    end else begin
      if (accept) acc_cnt <= acc_cnt + ADDR_ONE;
      if (s1_valid) begin
        wr_idx <= wr_idx + ADDR_ONE;
        if (|lane_sat) sat_flag <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) s1_data <= in_data;
      wr_en <= s1_valid;
      if (s1_valid) begin
        wr_addr <= cfg_base + wr_idx;
        wr_data <= rq_data;
      end
    end
  end

  for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
    requant_lane u_lane (
      .x     (s1_data[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW]),
      .shift (cfg_shift),
      .q     (rq_data[i*DATA_BW +: DATA_BW]),
      .sat   (lane_sat[i])
    );
  end

endmodule

// File: doc/result_writeback.md
Name: result_writeback

Overview:
- Sits directly downstream of the 1x64 vector multiplier.
- Captures each signed 64-lane partial-sum vector (24 bits per lane).
- Requantizes each lane to 8 bits using an arithmetic right shift, round-half-up and saturation.
- Writes the 8-bit vectors to the result/unified buffer at auto-incrementing addresses, then pulses done after a programmed row count.

Parameters:
- MATRIX_SIZE, 64: number of lanes per vector.
- PARTIAL_SUM_BW, 24: signed input lane width.
- DATA_BW, 8: signed output lane width.
- ADDRESSSIZE, 10: buffer address width.
- SHIFT_BW, 5: width of the requant shift amount.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches base_addr, num_rows and shift; ignored unless IDLE.
- base_addr  in  ADDRESSSIZE  first write address.
- num_rows  in  ADDRESSSIZE  vectors to write; 0 means done with no writes.
- shift  in  SHIFT_BW  right-shift amount, 0..PARTIAL_SUM_BW-1.
- in_valid  in  1  in_data holds a valid result vector.
- in_data  in  PARTIAL_SUM_BW*MATRIX_SIZE  signed lanes; lane i is bits [i*PSUM +: PSUM].
- in_ready  out  1  block accepts in_data this cycle.
- wr_en  out  1  buffer write strobe.
- wr_addr  out  ADDRESSSIZE  write address.
- wr_data  out  DATA_BW*MATRIX_SIZE  requantized lanes, same lane ordering as in_data.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle completion pulse.
- sat_flag  out  1  sticky; set if any lane saturated during the job.

Behaviour:
- Clocking and reset: single clock domain; reset is asynchronous and active-low (rstn).
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, sat_flag=0, FSM=IDLE, all counters 0.
- FSM states:
  - IDLE: on start, latch the config, clear sat_flag and go to RUN. If num_rows=0, go to DONE instead.
  - RUN: in_ready=1 while accepted count < num_rows. An accept is in_valid & in_ready. When the last vector is accepted, go to DRAIN.
  - DRAIN: in_ready=0; wait until the pipeline is empty, then go to DONE.
  - DONE: done=1 for exactly one cycle, then return to IDLE.
- Pipeline, 2 register stages:
  - S1 registers the accepted vector.
  - S2 registers the requantized data, drives wr_en=1 and wr_addr = base_addr + write index.
  - Latency from accept to wr_en is 2 cycles.
  - Full throughput: one vector per cycle, with no back-pressure from the buffer.
- Requant, per lane:
  - Round: r = (x + (shift>0 ? 1<<(shift-1) : 0)) >>> shift, computed at PARTIAL_SUM_BW+1 bits so the rounding add cannot overflow.
  - Saturate to the range [-128, 127].
  - Any lane that clips sets sat_flag. sat_flag holds until the next start.
- Address wrap: wr_addr wraps modulo 2^ADDRESSSIZE with no error.
- in_valid while in_ready=0: ignored. No data is captured and the upstream block must hold its data.
- start outside IDLE: ignored. The latched config is unchanged.
- The last accept and the pipeline-empty check in the same cycle: handled as DRAIN for one cycle, then DONE. done rises exactly 1 cycle after the final wr_en.
- Reset mid-job: all state and outputs return immediately to their reset values. The next job requires a new start.

Optional Feature:
- Macro: RESULT_WB_RELU_EN.
- When defined: ReLU is applied after the shift and before saturation, so negative lanes become 0. Negative values never set sat_flag.
- When undefined: signed saturation to [-128, 127] as described in Behaviour.

Decomposition:
- Shared package (vec_mul_pkg):
  - constants MATRIX_SIZE, PARTIAL_SUM_BW, DATA_BW.
  - SAT_MAX=127 and SAT_MIN=-128.
  - FSM state encoding: IDLE=0, RUN=1, DRAIN=2, DONE=3.
- Sub-module requant_lane:
  - Combinational shift, round and saturate for one lane, with a sat output.
  - Instantiated MATRIX_SIZE times by a generate loop.
  - The top module keeps the FSM, counters and pipeline registers.

Test Plan:
- Basic job: base_addr=0x010, num_rows=3, shift=4, in_valid held high, lane0 values 0x000100, 0x000018, 0xFFFFF8 -> wr_data lane0 = 0x10, 0x02, 0x00 at addresses 0x010..0x012; done 1 cycle after the last wr_en.
- Saturation: shift=0, lane5=0x000200, lane6=0xFFFE00 -> lane5=0x7F, lane6=0x80, sat_flag=1 (with RESULT_WB_RELU_EN: lane6=0x00).
- Back-to-back with gaps: in_valid toggled 1,0,1,1 with num_rows=3 -> exactly 3 writes at consecutive addresses; the in_valid asserted after the third accept is ignored.
- Wrap: base_addr=0x3FE, num_rows=4 -> writes to 0x3FE, 0x3FF, 0x000, 0x001.
- num_rows=0: start -> busy for 1 cycle, done pulse, no wr_en.
- Reset mid-job: rstn driven low during RUN after 2 accepts -> all outputs 0 immediately; a second start with num_rows=1 completes normally with 1 write.
